udp_tx_fifo_sched: RTL and testbench

//  Read-side scheduler for the UDP TX distributed FIFO. Watches the FIFO read water level and cuts the

---
 rtl/udp_tx_sched_pkg.sv | 27 ++
 rtl/udp_tx_fifo_sched.sv | 208 ++++++++++++++++++++
 tb/tb_udp_tx_fifo_sched.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_tx_sched_pkg.sv
// Shared types and helpers for the UDP TX FIFO read-side scheduler.
// Holds the scheduler state encoding, the length field width and the
// word-to-byte length conversion used when a packet request is issued.
package udp_tx_sched_pkg;

    // Width of the UDP payload length field presented to the stack.
    localparam int LEN_W = 16;

    // Scheduler phases, in the order a packet walks through them.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } sched_state_t;

    // Payload byte count for a packet of 'words' FIFO words.
    // The product is truncated to the length field width on purpose: the
    // stack only carries LEN_W bits and oversize configurations wrap.
    function automatic logic [LEN_W-1:0] bytes_of(input int unsigned words,
                                                  input int unsigned data_width);
        int unsigned bytes;
        bytes = words * (data_width / 8);
        return bytes[LEN_W-1:0];
    endfunction

endpackage

// File: rtl/udp_tx_fifo_sched.sv
// Read-side scheduler for the UDP TX distributed FIFO.
// Cuts the FIFO read stream into UDP packets: a full packet as soon as
// PKT_WORDS are available, or a flush of whatever is buffered once the
// level has sat non-zero (and short of a full packet) for TIMEOUT_CYC
// cycles. For each packet it requests the stack with a byte length, pops
// one FIFO word per stack word request, then holds off for GAP_CYC cycles.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a full packet or the idle timeout; timer = timeout
// REQ   | udp_tx_req high until the stack samples it with udp_tx_ready
// SEND  | one FIFO pop per udp_tx_data_req until words_left reaches 0
// GAP   | forced inter-packet gap; timer = remaining gap cycles
module udp_tx_fifo_sched #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int PKT_WORDS   = 256,
    parameter int TIMEOUT_CYC = 4096,
    parameter int GAP_CYC     = 12
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  enable,
    input  logic [ADDR_WIDTH:0]   fifo_rd_level,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  udp_tx_req,
    output logic [15:0]           udp_tx_len,
    input  logic                  udp_tx_ready,
    input  logic                  udp_tx_data_req,
    output logic [DATA_WIDTH-1:0] udp_tx_data,
    output logic                  udp_tx_data_valid,
    output logic                  busy,
    output logic [15:0]           pkt_cnt,
    output logic                  underrun_err
);

    import udp_tx_sched_pkg::*;

    // Parameter sanity: byte lengths need whole-byte words, and a full
    // packet must fit in the FIFO or the full-packet trigger never fires.
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_data_width
        $fatal(1, "udp_tx_fifo_sched: DATA_WIDTH must be a positive multiple of 8");
    end
    if (PKT_WORDS < 1 || PKT_WORDS > (2 ** ADDR_WIDTH)) begin : g_bad_pkt_words
        $fatal(1, "udp_tx_fifo_sched: PKT_WORDS must be in 1..2**ADDR_WIDTH");
    end
    if (TIMEOUT_CYC < 1 || GAP_CYC < 1) begin : g_bad_timers
        $fatal(1, "udp_tx_fifo_sched: TIMEOUT_CYC and GAP_CYC must be >= 1");
    end

    // One down-counter serves both the idle timeout and the gap, so it is
    // sized for whichever of the two is longer.
    localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [ADDR_WIDTH:0] LP_PKT_WORDS = (ADDR_WIDTH + 1)'(PKT_WORDS);
    localparam logic [ADDR_WIDTH:0] LP_WL_ONE    = (ADDR_WIDTH + 1)'(1);
    localparam logic [CNT_W-1:0]    LP_TMO_LOAD  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]    LP_GAP_LOAD  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0]    LP_CNT_ONE   = CNT_W'(1);
    localparam logic [LEN_W-1:0]    LP_PKT_ONE   = LEN_W'(1);

    sched_state_t            r_state;
    sched_state_t            w_state_nxt;
    logic [ADDR_WIDTH:0]     r_words_left;
    logic [ADDR_WIDTH:0]     w_words_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    w_start;

    logic [LEN_W-1:0]        r_len;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_valid;
    logic [LEN_W-1:0]        r_pkt_cnt;
    logic                    r_err;

    logic                    w_level_nz;
    logic                    w_level_full;
    logic                    w_accept;
    logic                    w_last;

    assign w_level_nz   = (fifo_rd_level != '0);
    assign w_level_full = (fifo_rd_level >= LP_PKT_WORDS);

    // A stack word request is consumed whenever the packet still owes
    // words, even if the FIFO is unexpectedly empty; that case emits a zero
    // word and flags an underrun so the advertised length stays honest.
    assign w_accept = (r_state == ST_SEND) && udp_tx_data_req && (r_words_left != '0);
    assign w_last   = w_accept && (r_words_left == LP_WL_ONE);

    assign fifo_rd_en        = w_accept && !fifo_empty;
    assign udp_tx_req        = (r_state == ST_REQ);
    assign busy              = (r_state != ST_IDLE);
    assign udp_tx_len        = r_len;
    assign udp_tx_data       = r_data;
    assign udp_tx_data_valid = r_valid;
    assign pkt_cnt           = r_pkt_cnt;
    assign underrun_err      = r_err;

    // Next-state, words-left and shared timer decode.
    always_comb begin
        w_state_nxt = r_state;
        w_words_nxt = r_words_left;
        w_cnt_nxt   = r_cnt;
        w_start     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!enable || !w_level_nz) begin
                    // Timeout restarts from scratch whenever nothing is pending.
                    w_cnt_nxt = LP_TMO_LOAD;
                end else if (w_level_full) begin
                    w_words_nxt = LP_PKT_WORDS;
                    w_state_nxt = ST_REQ;
                    w_start     = 1'b1;
                end else if (r_cnt == '0) begin
                    w_words_nxt = fifo_rd_level;
                    w_state_nxt = ST_REQ;
                    w_start     = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - LP_CNT_ONE;
                end
            end
            ST_REQ: begin
                if (udp_tx_ready) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_accept) begin
                    w_words_nxt = r_words_left - LP_WL_ONE;
                end
                if (w_last) begin
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = LP_GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = LP_TMO_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - LP_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = LP_TMO_LOAD;
            end
        endcase
    end

    // Control state registers. The timer resets to 0 in IDLE; the FIFO
    // shares rd_rst, so the level is 0 on the first cycle after reset and
    // the timer is reloaded before it can ever be taken as expired.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_state      <= ST_IDLE;
            r_words_left <= '0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_words_left <= w_words_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

    // Packet length latch: captured on the IDLE->REQ transition and held
    // until the next packet request.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_len <= '0;
        end else if (w_start) begin
            r_len <= bytes_of(32'(w_words_nxt), DATA_WIDTH);
        end
    end

    // Payload register: one-cycle latency from the pop to the valid pulse;
    // underrun slots carry zero data but still count against the length.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_data <= fifo_empty ? '0 : fifo_rd_data;
            end
        end
    end

    // Packet counter and sticky underrun flag.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_pkt_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_last) begin
                r_pkt_cnt <= r_pkt_cnt + LP_PKT_ONE;
            end
            if (w_accept && fifo_empty) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_udp_tx_fifo_sched.sv
// Bench for udp_tx_fifo_sched: a queue-backed FIFO feeds the DUT, a
// packet-level reference model tracks what every output must be, and a
// negedge process compares all outputs each cycle. Directed scenarios add
// literal expectations for lengths, timings and counts.
module tb_udp_tx_fifo_sched;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int PKT = 256;
    localparam int TMO = 4096;
    localparam int GAP = 12;

    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_SEND = 2;
    localparam int P_GAP  = 3;

    logic          rd_clk = 1'b0;
    logic          rd_rst;
    logic          enable;
    logic [AW:0]   fifo_rd_level;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_en;
    logic          udp_tx_req;
    logic [15:0]   udp_tx_len;
    logic          udp_tx_ready;
    logic          udp_tx_data_req;
    logic [DW-1:0] udp_tx_data;
    logic          udp_tx_data_valid;
    logic          busy;
    logic [15:0]   pkt_cnt;
    logic          underrun_err;

    udp_tx_fifo_sched #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .PKT_WORDS  (PKT),
        .TIMEOUT_CYC(TMO),
        .GAP_CYC    (GAP)
    ) dut (
        .rd_clk           (rd_clk),
        .rd_rst           (rd_rst),
        .enable           (enable),
        .fifo_rd_level    (fifo_rd_level),
        .fifo_empty       (fifo_empty),
        .fifo_rd_data     (fifo_rd_data),
        .fifo_rd_en       (fifo_rd_en),
        .udp_tx_req       (udp_tx_req),
        .udp_tx_len       (udp_tx_len),
        .udp_tx_ready     (udp_tx_ready),
        .udp_tx_data_req  (udp_tx_data_req),
        .udp_tx_data      (udp_tx_data),
        .udp_tx_data_valid(udp_tx_data_valid),
        .busy             (busy),
        .pkt_cnt          (pkt_cnt),
        .underrun_err     (underrun_err)
    );

    always #5 rd_clk = ~rd_clk;

    int checks   = 0;
    int failures = 0;

    // Bench FIFO
    logic [DW-1:0] fq[$];
    logic          force_empty = 1'b0;
    int unsigned   wr_seq      = 0;

    // Reference model: packet phase plus plain up-counting ages
    int            m_phase;
    int            m_age;
    int            m_gap;
    int            m_left;
    logic [15:0]   m_len;
    int            m_pkts;
    logic          m_err;
    logic          m_valid;
    logic [DW-1:0] m_data;

    // Measurements
    int cyc           = 0;
    int pops          = 0;
    int first_pop_cyc = 0;
    int last_pop_cyc  = 0;
    int req_seen      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait budget expired, got no event, required event (cycle %0d)", name, cyc);
    endtask

    task automatic drive_fifo_ports();
        fifo_rd_level = (AW + 1)'(fq.size());
        fifo_empty    = (fq.size() == 0) || force_empty;
        fifo_rd_data  = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            fq.push_back(32'hA500_0000 + DW'(wr_seq));
            wr_seq++;
        end
        drive_fifo_ports();
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_age   = 0;
        m_gap   = 0;
        m_left  = 0;
        m_len   = '0;
        m_pkts  = 0;
        m_err   = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
    endtask

    task automatic model_start(input int words);
        m_left  = words;
        m_len   = 16'(words * (DW / 8));
        m_phase = P_REQ;
        m_age   = 0;
    endtask

    task automatic model_step(input logic s_en, input int s_lvl, input logic s_ready,
                              input logic s_dreq, input logic s_empty, input logic [DW-1:0] s_head);
        m_valid = 1'b0;
        case (m_phase)
            P_IDLE: begin
                if (!s_en || s_lvl == 0)  m_age = 0;
                else if (s_lvl >= PKT)    model_start(PKT);
                else if (m_age == TMO)    model_start(s_lvl);
                else                      m_age++;
            end
            P_REQ: if (s_ready) m_phase = P_SEND;
            P_SEND: begin
                if (s_dreq && m_left != 0) begin
                    m_valid = 1'b1;
                    m_data  = s_empty ? '0 : s_head;
                    if (s_empty) m_err = 1'b1;
                    m_left--;
                    if (m_left == 0) begin
                        m_pkts++;
                        m_phase = P_GAP;
                        m_gap   = 0;
                    end
                end
            end
            default: begin
                m_gap++;
                if (m_gap == GAP) m_phase = P_IDLE;
            end
        endcase
    endtask

    // One clock: sample inputs at the edge, then update model, FIFO and stats
    task automatic cycle();
        logic          s_rd_en, s_dreq, s_ready, s_en, s_empty;
        int            s_lvl;
        logic [DW-1:0] s_head;
        @(posedge rd_clk);
        s_rd_en = fifo_rd_en;
        s_dreq  = udp_tx_data_req;
        s_ready = udp_tx_ready;
        s_en    = enable;
        s_empty = fifo_empty;
        s_lvl   = int'(fifo_rd_level);
        s_head  = fifo_rd_data;
        #1;
        cyc++;
        if (rd_rst) begin
            model_reset();
        end else begin
            model_step(s_en, s_lvl, s_ready, s_dreq, s_empty, s_head);
            if (s_rd_en) begin
                if (fq.size() != 0) fq.delete(0);
                pops++;
                if (pops == 1) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
            end
        end
        if (udp_tx_req) req_seen++;
        drive_fifo_ports();
    endtask

    task automatic wait_pkts(input int want, input int budget, input string name);
        int n = 0;
        while (m_pkts < want && n < budget) begin cycle(); n++; end
        if (m_pkts < want) wait_fail(name);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (m_phase != P_IDLE && n < budget) begin cycle(); n++; end
        if (m_phase != P_IDLE) wait_fail(name);
    endtask

    task automatic wait_req(input int budget, input string name, output int n);
        n = 0;
        do begin cycle(); n++; end while (!udp_tx_req && n < budget);
        if (!udp_tx_req) wait_fail(name);
    endtask

    task automatic wait_pops(input int want, input int budget, input string name);
        int n = 0;
        while (pops < want && n < budget) begin cycle(); n++; end
        if (pops < want) wait_fail(name);
    endtask

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge rd_clk) begin
        chk("req",     64'(udp_tx_req),        64'(m_phase == P_REQ));
        chk("busy",    64'(busy),              64'(m_phase != P_IDLE));
        chk("rd_en",   64'(fifo_rd_en),        64'(m_phase == P_SEND && udp_tx_data_req && m_left != 0 && !fifo_empty));
        chk("valid",   64'(udp_tx_data_valid), 64'(m_valid));
        chk("data",    64'(udp_tx_data),       64'(m_data));
        chk("len",     64'(udp_tx_len),        64'(m_len));
        chk("pkt_cnt", 64'(pkt_cnt),           64'(16'(m_pkts)));
        chk("err",     64'(underrun_err),      64'(m_err));
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int end_cyc;
        int ready_cyc;

        rd_rst          = 1'b1;
        enable          = 1'b0;
        udp_tx_ready    = 1'b0;
        udp_tx_data_req = 1'b0;
        model_reset();
        drive_fifo_ports();
        repeat (3) cycle();
        rd_rst = 1'b0;
        cycle();
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("rst_len",     64'(udp_tx_len), 64'd0);
        chk("rst_busy",    64'(busy), 64'd0);

        // T1: full packet, stack always ready
        enable          = 1'b1;
        udp_tx_ready    = 1'b1;
        udp_tx_data_req = 1'b1;
        pops = 0; req_seen = 0;
        push(256);
        wait_pkts(1, 600, "t1_done");
        chk("t1_len",       64'(udp_tx_len), 64'd1024);
        chk("t1_req_cyc",   64'(req_seen), 64'd1);
        chk("t1_pops",      64'(pops), 64'd256);
        chk("t1_burst",     64'(last_pop_cyc - first_pop_cyc), 64'd255);
        cycle();
        chk("t1_last_word", 64'(udp_tx_data), 64'h0000_0000_A500_00FF);
        wait_idle(100, "t1_idle");
        chk("t1_pkt_cnt",   64'(pkt_cnt), 64'd1);

        // T2: partial packet flushed by the idle timeout
        pops = 0;
        push(10);
        wait_req(5000, "t2_req", n);
        chk("t2_tmo_wait",  64'(n), 64'(TMO + 1));
        chk("t2_len",       64'(udp_tx_len), 64'd40);
        wait_pkts(2, 200, "t2_done");
        wait_idle(100, "t2_idle");
        chk("t2_pops",      64'(pops), 64'd10);
        chk("t2_pkt_cnt",   64'(pkt_cnt), 64'd2);

        // T3: 600 words -> two full packets then a 88-word flush
        pops = 0;
        push(600);
        wait_pkts(3, 700, "t3_pkt1");
        end_cyc = last_pop_cyc;
        wait_req(100, "t3_req2", n);
        chk("t3_gap_ok",    64'((cyc - end_cyc) >= GAP + 1), 64'd1);
        chk("t3_len2",      64'(udp_tx_len), 64'd1024);
        wait_pkts(4, 700, "t3_pkt2");
        wait_idle(100, "t3_idle2");
        wait_req(5000, "t3_flush", n);
        chk("t3_len3",      64'(udp_tx_len), 64'd352);
        wait_pkts(5, 300, "t3_pkt3");
        wait_idle(100, "t3_idle3");
        chk("t3_pkt_cnt",   64'(pkt_cnt), 64'd5);
        chk("t3_pops",      64'(pops), 64'd600);

        // T4: stack holds off ready for 50 cycles
        pops = 0;
        udp_tx_ready = 1'b0;
        push(256);
        wait_req(50, "t4_req", n);
        req_seen = 0;
        repeat (50) cycle();
        chk("t4_req_held",  64'(req_seen), 64'd50);
        chk("t4_no_pops",   64'(pops), 64'd0);
        udp_tx_ready = 1'b1;
        cycle();
        ready_cyc = cyc;
        chk("t4_req_drop",  64'(udp_tx_req), 64'd0);
        wait_pkts(6, 600, "t4_done");
        chk("t4_first_pop", 64'(first_pop_cyc - ready_cyc), 64'd1);
        chk("t4_pops",      64'(pops), 64'd256);
        wait_idle(100, "t4_idle");

        // T5: FIFO reports empty for 20 cycles in the middle of SEND
        pops = 0;
        push(256);
        wait_pops(100, 600, "t5_pops100");
        force_empty = 1'b1;
        drive_fifo_ports();
        repeat (20) cycle();
        chk("t5_err_set",   64'(underrun_err), 64'd1);
        force_empty = 1'b0;
        drive_fifo_ports();
        wait_pkts(7, 600, "t5_done");
        wait_idle(100, "t5_idle");
        chk("t5_pops",      64'(pops), 64'd236);
        chk("t5_pkt_cnt",   64'(pkt_cnt), 64'd7);
        repeat (5) cycle();
        chk("t5_err_stky",  64'(underrun_err), 64'd1);

        // T6: asynchronous reset in the middle of SEND
        pops = 0;
        push(300);
        wait_pops(50, 600, "t6_pops50");
        rd_rst = 1'b1;
        #1;
        chk("t6_rst_req",   64'(udp_tx_req), 64'd0);
        chk("t6_rst_busy",  64'(busy), 64'd0);
        chk("t6_rst_rden",  64'(fifo_rd_en), 64'd0);
        chk("t6_rst_valid", 64'(udp_tx_data_valid), 64'd0);
        chk("t6_rst_data",  64'(udp_tx_data), 64'd0);
        chk("t6_rst_len",   64'(udp_tx_len), 64'd0);
        chk("t6_rst_pkts",  64'(pkt_cnt), 64'd0);
        chk("t6_rst_err",   64'(underrun_err), 64'd0);
        fq.delete();
        model_reset();
        drive_fifo_ports();
        repeat (2) cycle();
        rd_rst = 1'b0;
        cycle();

        // T6b: enable drops mid-packet; packet completes, nothing new starts
        pops = 0;
        push(256);
        wait_pops(10, 600, "t6_pops10");
        enable = 1'b0;
        wait_pkts(1, 600, "t6_done");
        wait_idle(100, "t6_idle");
        chk("t6_pkt_cnt",   64'(pkt_cnt), 64'd1);
        chk("t6_pops",      64'(pops), 64'd256);
        push(300);
        req_seen = 0;
        repeat (300) cycle();
        chk("t6_no_req",    64'(req_seen), 64'd0);
        chk("t6_not_busy",  64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
